// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: one cell of the linear systolic array with PASS / LOAD / MAC / SWAP modes.
// Latency: MUL_LAT+1 enabled cycles from issue to x_out/c_out/mode_out/vld_out; p_out updates 1 cycle after issue.
// Backpressure: none beyond the global en stall, which freezes every register including p and ovf.
//
// Ports:
//   clk, rst (sync, active-low), en (global advance)
//   c_in/c_out      coefficient, delayed by L = MUL_LAT+1 so the next cell sees it aligned
//   x_in/x_out      partial-sum chain (weight rides on the low DW bits for LOAD/SWAP)
//   mode_in/mode_out, vld_in/vld_out  side-band, delayed by L alongside x
//   p_out           stationary weight register (readback), ovf  sticky overflow flag
//
// AW must be at least 2*DW; the extension widths below rely on it.
module systolic_mac_pe #(
    parameter int DW      = 16,
    parameter int AW      = 32,
    parameter int MUL_LAT = 1,
    parameter int SAT     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] c_in,
    input  logic [AW-1:0] x_in,
    input  logic [1:0]    mode_in,
    input  logic          vld_in,
    output logic [DW-1:0] c_out,
    output logic [AW-1:0] x_out,
    output logic [1:0]    mode_out,
    output logic          vld_out,
    output logic [DW-1:0] p_out,
    output logic          ovf
);

    localparam int L = MUL_LAT + 1;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SWAP = 2'b11;

    // Weight register and sticky flag.
    logic [DW-1:0] p_q;
    logic          ovf_q;

    // Pipeline: stage 0 is written at the issue edge, stage L-1 drives the outputs.
    logic [AW-1:0] x_q    [L];
    logic [DW-1:0] c_q    [L];
    logic [1:0]    mode_q [L];
    logic          vld_q  [L];

    // Issue-stage datapath.
    logic [DW-1:0]   w;
    logic [DW-1:0]   mul_b;
    logic [2*DW-1:0] prod;
    logic [AW:0]     prod_ext;
    logic [AW:0]     addend;
    logic [AW:0]     sum;
    logic            sum_ovf;
    logic [AW-1:0]   arith_res;
    logic [AW-1:0]   x_d;

    always_comb begin
        w     = x_in[DW-1:0];
        // SWAP multiplies by the incoming weight; MAC uses the stationary p_old.
        mul_b = (mode_in == MODE_SWAP) ? w : p_q;
        // Operands sign-extended to 2*DW so the low 2*DW bits of the product are the signed result.
        prod  = {{DW{c_in[DW-1]}}, c_in} * {{DW{mul_b[DW-1]}}, mul_b};

        prod_ext = {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
        addend   = (mode_in == MODE_SWAP) ? {{(AW+1-DW){p_q[DW-1]}}, p_q}
                                          : {x_in[AW-1], x_in};
        sum      = prod_ext + addend;

        // One guard bit: the sum is out of AW-bit range exactly when the top two bits differ.
        sum_ovf = mode_in[1] && (sum[AW] != sum[AW-1]);

        if (sum_ovf && (SAT != 0)) begin
            arith_res = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            arith_res = sum[AW-1:0];
        end

        case (mode_in)
            MODE_PASS: x_d = x_in;
            MODE_LOAD: x_d = {{(AW-DW){p_q[DW-1]}}, p_q};
            default:   x_d = arith_res;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_q   <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < L; i++) begin
                x_q[i]    <= '0;
                c_q[i]    <= '0;
                mode_q[i] <= '0;
                vld_q[i]  <= 1'b0;
            end
        end else if (en) begin
            // Bubbles still shift their (meaningless) payload so side-band stays aligned.
            x_q[0]    <= x_d;
            c_q[0]    <= c_in;
            mode_q[0] <= mode_in;
            vld_q[0]  <= vld_in;
            for (int i = 1; i < L; i++) begin
                x_q[i]    <= x_q[i-1];
                c_q[i]    <= c_q[i-1];
                mode_q[i] <= mode_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
            if (vld_in) begin
                // LOAD (01) and SWAP (11) both capture the new weight.
                if (mode_in[0]) begin
                    p_q <= w;
                end
                if (sum_ovf) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign x_out    = x_q[L-1];
    assign c_out    = c_q[L-1];
    assign mode_out = mode_q[L-1];
    assign vld_out  = vld_q[L-1];
    assign p_out    = p_q;
    assign ovf      = ovf_q;

endmodule
